// File: rtl/mips_register_file.sv
// 32x32 MIPS general-purpose register file.
// Two combinational read ports with write-through bypass, one write port whose
// destination comes from regDst (rt / rd / link register), and a small set of
// registered status flags describing the most recent write attempt.
// Register $0 is never written and always reads as zero.
module mips_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [1:0]        regDst,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [ADDR_W-1:0] lastWrAddr,
  output logic              lastWrValid,
  output logic              illegalDst
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wa;
  logic              wa_legal;
  logic              commit;

  // Destination decode; regDst==11 has no legal destination.
  always_comb begin
    wa       = '0;
    wa_legal = 1'b0;
    case (regDst)
      2'b00:   begin wa = rt; wa_legal = 1'b1; end
      2'b01:   begin wa = rd; wa_legal = 1'b1; end
      2'b10:   begin wa = ADDR_W'(LINK_REG); wa_legal = 1'b1; end
      default: begin wa = '0; wa_legal = 1'b0; end
    endcase
  end

  // A write commits only outside reset, to a legal, non-zero destination.
  // The same term gates the bypass so reset also suppresses forwarding.
  assign commit = rst_n && regWrite && wa_legal && (wa != '0);

  // Register array: cleared on reset, written one entry per committed write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[wa] <= writedata;
    end
  end

  // Status flags describing the write attempt of the previous cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastWrAddr  <= '0;
      lastWrValid <= 1'b0;
      illegalDst  <= 1'b0;
    end else begin
      if (commit) begin
        lastWrAddr <= wa;
      end
      lastWrValid <= commit;
      illegalDst  <= regWrite && (regDst == 2'b11);
    end
  end

  // Read ports: $0 reads zero, a same-cycle commit to the index is forwarded,
  // otherwise the stored value is returned.
  always_comb begin
    readData1 = mem[readReg1];
    readData2 = mem[readReg2];
    if (readReg1 == '0) begin
      readData1 = '0;
    end else if (commit && (readReg1 == wa)) begin
      readData1 = writedata;
    end
    if (readReg2 == '0) begin
      readData2 = '0;
    end else if (commit && (readReg2 == wa)) begin
      readData2 = writedata;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: a reference model produces the
// expected outputs of every cycle into a queue, which is drained and compared
// against the DUT half a clock later.
module tb_mips_register_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        regWrite;
  logic [1:0]  regDst;
  logic [4:0]  rt, rd, readReg1, readReg2;
  logic [31:0] writedata;
  logic [31:0] readData1, readData2;
  logic [4:0]  lastWrAddr;
  logic        lastWrValid, illegalDst;

  mips_register_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .rt         (rt),
    .rd         (rd),
    .writedata  (writedata),
    .readReg1   (readReg1),
    .readReg2   (readReg2),
    .readData1  (readData1),
    .readData2  (readData2),
    .lastWrAddr (lastWrAddr),
    .lastWrValid(lastWrValid),
    .illegalDst (illegalDst)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // reference model state
  logic [31:0] ref_mem [32];
  logic [4:0]  ref_last_addr;
  logic        ref_last_valid;
  logic        ref_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic cm,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (cm && idx == wa) return wd;
    return ref_mem[idx];
  endfunction

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0x%08h, expected an entry", tag, obs);
    end else begin
      check({tag_q.pop_front(), "/", tag}, obs, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle, queue the model's expectations, compare at the falling
  // edge, then advance the model across the rising edge.
  task automatic cyc(input string tag, input logic rn, input logic we, input logic [1:0] dst,
                     input logic [4:0] t, input logic [4:0] d, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2);
    logic [4:0] wa;
    logic       legal, cm;
    rst_n = rn; regWrite = we; regDst = dst; rt = t; rd = d;
    writedata = wd; readReg1 = r1; readReg2 = r2;
    legal = (dst != 2'b11);
    wa    = (dst == 2'b00) ? t : (dst == 2'b01) ? d : 5'd31;
    cm    = rn && we && legal && (wa != 5'd0);
    exp_q.push_back(model_read(r1, cm, wa, wd));       tag_q.push_back(tag);
    exp_q.push_back(model_read(r2, cm, wa, wd));       tag_q.push_back(tag);
    exp_q.push_back(32'(ref_last_addr));               tag_q.push_back(tag);
    exp_q.push_back(32'(ref_last_valid));              tag_q.push_back(tag);
    exp_q.push_back(32'(ref_illegal));                 tag_q.push_back(tag);
    @(negedge clk);
    pop_check("rd1", readData1);
    pop_check("rd2", readData2);
    pop_check("last_addr", 32'(lastWrAddr));
    pop_check("last_valid", 32'(lastWrValid));
    pop_check("illegal", 32'(illegalDst));
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
      ref_last_addr = 5'd0; ref_last_valid = 1'b0; ref_illegal = 1'b0;
    end else begin
      if (cm) begin
        ref_mem[wa]   = wd;
        ref_last_addr = wa;
      end
      ref_last_valid = cm;
      ref_illegal    = we && (dst == 2'b11);
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; regWrite = 1'b0; regDst = 2'b00; rt = '0; rd = '0;
    writedata = '0; readReg1 = '0; readReg2 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    ref_last_addr = 5'd0; ref_last_valid = 1'b0; ref_illegal = 1'b0;
    @(posedge clk);
    #1;

    // 1. random writes, then reset clears everything
    for (int i = 0; i < 20; i++)
      cyc("rnd_wr", 1'b1, 1'b1, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    cyc("reset", 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd1, 5'd2);
    for (int i = 1; i < 32; i += 2)
      cyc("post_reset", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'(i), 5'(i + 1));

    // seed registers whose contents must survive the directed writes
    cyc("seed9", 1'b1, 1'b1, 2'b00, 5'd9, 5'd0, 32'hCAFE0009, 5'd9, 5'd0);
    cyc("seed3", 1'b1, 1'b1, 2'b01, 5'd0, 5'd3, 32'hCAFE0003, 5'd3, 5'd0);
    cyc("seed7", 1'b1, 1'b1, 2'b01, 5'd0, 5'd7, 32'hCAFE0007, 5'd7, 5'd0);

    // 2. R-type write with same-cycle bypass, then array check
    cyc("rtype", 1'b1, 1'b1, 2'b01, 5'd9, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    cyc("rtype_next", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd5, 5'd9);

    // 3. link write goes to $31
    cyc("link", 1'b1, 1'b1, 2'b10, 5'd0, 5'd3, 32'h00400010, 5'd31, 5'd3);
    cyc("link_next", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd31, 5'd3);

    // 4. $0 protection
    cyc("zero_wr", 1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cyc("zero_next", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd0, 5'd31);

    // 5. illegal destination
    cyc("illegal", 1'b1, 1'b1, 2'b11, 5'd0, 5'd7, 32'h00001234, 5'd7, 5'd7);
    cyc("illegal_next", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd7, 5'd0);
    cyc("illegal_clr", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd7, 5'd5);

    // 6. reset collides with a write: no bypass, no commit
    cyc("rst_collide", 1'b0, 1'b1, 2'b01, 5'd0, 5'd4, 32'h00000055, 5'd4, 5'd4);
    cyc("rst_collide_next", 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 5'd4, 5'd5);

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++)
      cyc("random", ($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
